// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low patterns, bus sizes and
// select-line classification used by the scan decoder.
package seg7_pkg;

  localparam int SEG_W      = 7;
  localparam int NUM_DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  typedef enum logic [1:0] {
    SEL_BLANK = 2'd0,
    SEL_VALID = 2'd1,
    SEL_ERR   = 2'd2
  } sel_class_e;

  typedef struct packed {
    sel_class_e cls;
    logic [1:0] idx;
  } sel_info_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_e;

  function automatic sel_info_t classify_sel(input logic [NUM_DIGITS-1:0] sel);
    sel_info_t info;
    info.cls = SEL_ERR;
    info.idx = 2'd0;
    case (sel)
      4'b1111: info.cls = SEL_BLANK;
      4'b1110: begin info.cls = SEL_VALID; info.idx = 2'd0; end
      4'b1101: begin info.cls = SEL_VALID; info.idx = 2'd1; end
      4'b1011: begin info.cls = SEL_VALID; info.idx = 2'd2; end
      4'b0111: begin info.cls = SEL_VALID; info.idx = 2'd3; end
      default: info.cls = SEL_ERR;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational reverse lookup: active-low segment pattern to hex digit.
// Unrecognised patterns report value 0 with known cleared.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic [3:0]       value_o,
  output logic             known_o
);

  // Table lookup against the shared encoder patterns
  always_comb begin
    value_o = 4'h0;
    known_o = 1'b1;
    case (pattern_i)
      SEG_0:   value_o = 4'h0;
      SEG_1:   value_o = 4'h1;
      SEG_2:   value_o = 4'h2;
      SEG_3:   value_o = 4'h3;
      SEG_4:   value_o = 4'h4;
      SEG_5:   value_o = 4'h5;
      SEG_6:   value_o = 4'h6;
      SEG_7:   value_o = 4'h7;
      SEG_8:   value_o = 4'h8;
      SEG_9:   value_o = 4'h9;
      SEG_A:   value_o = 4'hA;
      SEG_B:   value_o = 4'hB;
      SEG_C:   value_o = 4'hC;
      SEG_D:   value_o = 4'hD;
      SEG_E:   value_o = 4'hE;
      SEG_F:   value_o = 4'hF;
      default: begin
        value_o = 4'h0;
        known_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed active-low 4-digit 7-segment bus:
// glitch-filters each digit dwell, assembles frames, presents them on valid/ready.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SEG_W-1:0]        i_seg,
  input  logic [NUM_DIGITS-1:0]   i_dig_sel,
  input  logic                    i_ready,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_known,
  output logic                    o_valid,
  output logic                    o_overrun,
  output logic                    o_sel_err
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  sel_info_t                 sel_s;
  logic                      same_s;
  logic                      capture_s;
  logic                      frame_done_s;
  logic [3:0]                dec_val_s;
  logic                      dec_known_s;

  scan_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]     last_sel_q;
  logic [SEG_W-1:0]          last_seg_q;
  logic [NUM_DIGITS-1:0]     mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0]   stage_val_q, stage_val_d;
  logic [NUM_DIGITS-1:0]     stage_known_q, stage_known_d;
  logic [4*NUM_DIGITS-1:0]   value_q, value_d;
  logic [NUM_DIGITS-1:0]     known_q, known_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      sel_err_q, sel_err_d;

  seg7_pattern_decoder u_dec (
    .pattern_i (i_seg),
    .value_o   (dec_val_s),
    .known_o   (dec_known_s)
  );

  // Next-state: dwell filter, staging/mask update and output handshake
  always_comb begin
    sel_s         = classify_sel(i_dig_sel);
    same_s        = (i_dig_sel == last_sel_q) && (i_seg == last_seg_q);
    state_d       = ST_IDLE;
    cnt_d         = {CNT_W{1'b0}};
    capture_s     = 1'b0;
    mask_d        = mask_q;
    stage_val_d   = stage_val_q;
    stage_known_d = stage_known_q;
    value_d       = value_q;
    known_d       = known_q;
    valid_d       = valid_q;
    overrun_d     = 1'b0;
    sel_err_d     = (sel_s.cls == SEL_ERR);

    if (sel_s.cls == SEL_VALID) begin
      if (same_s) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end else begin
        cnt_d = CNT_ONE;
      end
      // A dwell that already captured stays quiet until sample or select changes
      if (same_s && (state_q == ST_CAPTURED)) begin
        state_d = ST_CAPTURED;
      end else if (cnt_d == CNT_MAX) begin
        state_d   = ST_CAPTURED;
        capture_s = 1'b1;
      end else begin
        state_d = ST_SETTLE;
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end

    frame_done_s = (mask_q == {NUM_DIGITS{1'b1}});
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (capture_s && (sel_s.idx == k[1:0])) begin
        mask_d[k]              = 1'b1;
        stage_val_d[4*k +: 4]  = dec_val_s;
        stage_known_d[k]       = dec_known_s;
      end else begin
        mask_d[k]              = frame_done_s ? 1'b0 : mask_q[k];
        stage_val_d[4*k +: 4]  = stage_val_q[4*k +: 4];
        stage_known_d[k]       = stage_known_q[k];
      end
    end

    if (frame_done_s) begin
      value_d   = stage_val_q;
      known_d   = stage_known_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !i_ready;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      last_sel_q    <= {NUM_DIGITS{1'b0}};
      last_seg_q    <= {SEG_W{1'b0}};
      mask_q        <= {NUM_DIGITS{1'b0}};
      stage_val_q   <= {(4*NUM_DIGITS){1'b0}};
      stage_known_q <= {NUM_DIGITS{1'b0}};
      value_q       <= {(4*NUM_DIGITS){1'b0}};
      known_q       <= {NUM_DIGITS{1'b0}};
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_sel_q    <= i_dig_sel;
      last_seg_q    <= i_seg;
      mask_q        <= mask_d;
      stage_val_q   <= stage_val_d;
      stage_known_q <= stage_known_d;
      value_q       <= value_d;
      known_q       <= known_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign o_value   = value_q;
  assign o_known   = known_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
  assign o_sel_err = sel_err_q;

endmodule
